fa_serial_adder_ctrl: RTL and testbench

//   Bit-serial adder controller: sequences ONE full-adder cell over WIDTH clock

---
 rtl/fa_serial_adder_ctrl_pkg.sv | 16 +
 rtl/fa_dataflow.sv | 13 +
 rtl/fa_serial_adder_ctrl.sv | 106 ++++++++++
 tb/tb_fa_serial_adder_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fa_serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the bit-counter width helper.
package fa_serial_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAdd  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Counter must hold 0..width without wrapping inside one operation.
   function automatic int unsigned cnt_w(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/fa_dataflow.sv
// Combinational full-adder cell used as the single bit slice of the serial adder.
module fa_dataflow (
   output logic s,
   output logic co,
   input  logic a,
   input  logic b,
   input  logic ci
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/fa_serial_adder_ctrl.sv
// Bit-serial adder: walks one full-adder cell across WIDTH bits, LSB first,
// feeding the carry back each cycle; start/busy/done handshake.
module fa_serial_adder_ctrl
   import fa_serial_adder_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   localparam int unsigned    CntW    = cnt_w(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH:0]   sum_ext;
   logic             carry_q, carry_d;
   logic             co_q, co_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             s_cell, co_cell;

   fa_dataflow u_cell (
      .s  (s_cell),
      .co (co_cell),
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .ci (carry_q)
   );

   // New bit enters at the MSB; written this way so WIDTH=1 stays legal.
   assign sum_ext = {s_cell, sum_q};

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      co_d    = co_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = ci;
               cnt_d   = '0;
               sum_d   = '0;
               co_d    = 1'b0;
               state_d = StAdd;
            end
         end
         StAdd: begin
            sum_d   = sum_ext[WIDTH:1];
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = co_cell;
            cnt_d   = cnt_q + CntOne;
            if (cnt_q == CntLast) begin
               co_d    = co_cell;
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         co_q    <= co_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q == StAdd) || (state_q == StDone);
   assign done = (state_q == StDone);
   assign sum  = sum_q;
   assign co   = co_q;

endmodule

// File: tb/tb_fa_serial_adder_ctrl.sv
// Directed and random bench for the serial adder; WIDTH=8 main instance plus a
// WIDTH=1 instance, results checked through scoreboard queues.
module tb_fa_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         ci;
   logic         busy, done;
   logic [W-1:0] sum;
   logic         co;

   logic start1, a1, b1, ci1;
   logic busy1, done1, sum1, co1;

   int checks = 0;
   int errors = 0;

   logic [W:0] exp_q[$];
   logic [1:0] exp1_q[$];

   always #5 clk = ~clk;

   fa_serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .ci    (ci),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .co    (co)
   );

   fa_serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .ci    (ci1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .co    (co1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input string tag, input bit poke);
      logic [W:0] want;
      logic [W:0] ref_v;
      logic [W-1:0] held;
      int n;
      a = av; b = bv; ci = cv; start = 1'b1;
      @(posedge clk);
      ref_v = av + bv + {{W{1'b0}}, cv};
      exp_q.push_back(ref_v);
      #1;
      start = 1'b0;
      check({tag, " busy"}, busy, 1);
      n = 0;
      while (!done && n < 4 * W) begin
         if (poke && n == 2) begin
            start = 1'b1; a = 8'h01; b = 8'h00; ci = 1'b0;
         end
         @(posedge clk);
         #1;
         n++;
         start = 1'b0;
      end
      check({tag, " latency"}, n, W);
      check({tag, " sb depth"}, exp_q.size(), 1);
      if (exp_q.size() != 0) begin
         want = exp_q.pop_front();
         check({tag, " sum"}, sum, want[W-1:0]);
         check({tag, " co"}, co, want[W]);
      end
      held = sum;
      @(posedge clk);
      #1;
      check({tag, " done pulse"}, done, 0);
      repeat (3) @(posedge clk);
      #1;
      check({tag, " idle done"}, done, 0);
      check({tag, " idle busy"}, busy, 0);
      check({tag, " sum held"}, sum, held);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W:0] want;
      logic [W:0] ref_v;
      logic [1:0] want1;
      logic [1:0] ref1;
      logic [2:0] v;
      time        t_last, t_now;
      int         n;
      bit         seen;

      rst_n = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset sum", sum, 0);
      check("reset co", co, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op(8'h00, 8'h00, 1'b0, "zero", 1'b0);
      run_op(8'hFF, 8'h01, 1'b0, "ff+01", 1'b0);
      run_op(8'hFF, 8'hFF, 1'b1, "ff+ff+1", 1'b0);
      run_op(8'h5A, 8'hA5, 1'b0, "5a+a5 poke", 1'b1);

      // Abandon an operation three bits in.
      a = 8'h33; b = 8'h44; ci = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset busy", busy, 0);
      check("midreset done", done, 0);
      check("midreset sum", sum, 0);
      check("midreset co", co, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      check("midreset no done", seen, 0);
      run_op(8'h0F, 8'h01, 1'b0, "0f+01", 1'b0);

      for (int k = 0; k < 8; k++) begin
         v = 3'(k);
         ci1 = v[2]; a1 = v[1]; b1 = v[0]; start1 = 1'b1;
         @(posedge clk);
         ref1 = {1'b0, v[1]} + {1'b0, v[0]} + {1'b0, v[2]};
         exp1_q.push_back(ref1);
         #1;
         start1 = 1'b0;
         n = 0;
         while (!done1 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
         end
         check("w1 latency", n, 1);
         check("w1 sb depth", exp1_q.size(), 1);
         if (exp1_q.size() != 0) begin
            want1 = exp1_q.pop_front();
            check("w1 result", {co1, sum1}, want1);
         end
         @(posedge clk);
         #1;
      end

      t_last = 0;
      start = 1'b1;
      a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         ref_v = a + b + {{W{1'b0}}, ci};
         exp_q.push_back(ref_v);
         #1;
         n = 0;
         while (!done && n < 4 * W) begin
            @(posedge clk);
            #1;
            n++;
         end
         check("rand done", done, 1);
         if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check("rand result", {co, sum}, want);
         end
         t_now = $time;
         if (i > 0) check("rand spacing", t_now - t_last, 100);
         t_last = t_now;
         a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("final sb empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
